led_pwm_fader: RTL
==================

LED_PWM_FADER -- requirements
Module: led_pwm_fader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the PWM/duty resolution in bits.
REQ-002 The block SHALL have parameter CHANNELS, default 3, setting the number of LED channels (R, G, B).
REQ-003 The block SHALL have port clk_in, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-005 The block SHALL have port tick_in, input, 1 bit: divided clock from the upstream variable clock divider; each toggle is one PWM tick.
REQ-006 The block SHALL have port enable, input, 1 bit: 1 = run PWM and fades, 0 = outputs dark and fades frozen.
REQ-007 The block SHALL have port cmd_valid, input, 1 bit: a fade command is presented.
REQ-008 The block SHALL have port cmd_ready, output, 1 bit: the block can accept a command this cycle.
REQ-009 The block SHALL have port cmd_channel, input, max(1,$clog2(CHANNELS)) bits: the target channel index.
REQ-010 The block SHALL have port cmd_target, input, WIDTH bits: the target duty.
REQ-011 The block SHALL have port cmd_step, input, WIDTH bits: the duty change per PWM period; 0 = jump immediately.
REQ-012 The block SHALL have port pwm_out, output, CHANNELS bits: registered PWM drive, one bit per LED.
REQ-013 The block SHALL have port busy, output, CHANNELS bits: 1 while that channel is fading.
REQ-014 The block SHALL have port period_strobe, output, 1 bit: a one-cycle pulse at each PWM period wrap.

Function
REQ-015 The block SHALL synchronise tick_in through 2 flops plus an edge register; a tick SHALL be any change (rise or fall), and pwm_cnt SHALL update on the 3rd clk_in rising edge after tick_in changes.
REQ-016 The block SHALL keep pwm_cnt (WIDTH bits) counting 0..MAX-1, where MAX = 2^WIDTH-1, advancing by one per tick while enable=1.
REQ-017 On a tick with pwm_cnt == MAX-1 the block SHALL set pwm_cnt to 0 and pulse period_strobe high for exactly 1 clk_in cycle (the wrap cycle).
REQ-018 The block SHALL compute pwm_out[i] = (pwm_cnt < duty[i]), registered with 1 cycle of latency; duty 0 gives always off and duty MAX gives always on.
REQ-019 Each channel SHALL run an FSM with states IDLE, FADE_UP and FADE_DOWN, and busy[i] SHALL be 1 when the channel is not in IDLE.
REQ-020 On command accept, if cmd_step = 0 the block SHALL set duty = target on the next edge and stay in IDLE; otherwise it SHALL enter FADE_UP if target > duty, FADE_DOWN if target < duty, or IDLE if they are equal.
REQ-021 On each wrap in FADE_UP the block SHALL set duty = min(duty+step, target), computed in WIDTH+1 bits with no overflow.
REQ-022 On each wrap in FADE_DOWN the block SHALL set duty = max(duty-step, target), with no underflow.
REQ-023 When duty reaches target the channel SHALL go to IDLE on the same edge.
REQ-024 A command is accepted when cmd_valid and cmd_ready are both 1; the block SHALL latch target, step and direction on that edge.
REQ-025 A command to a channel already fading SHALL replace its target and step, with direction recomputed from the current duty.
REQ-026 The block SHALL accept a command with cmd_channel >= CHANNELS and ignore it, with no state change.
REQ-027 cmd_ready SHALL be registered and SHALL be 0 during the wrap cycle (period_strobe=1), so a fade update and a command can never collide; it SHALL be 1 otherwise.
REQ-028 When enable=0 the block SHALL hold pwm_out at 0 and pwm_cnt at its current value, ignore ticks, and freeze fades; commands SHALL still be accepted, and step=0 jumps SHALL still apply.
REQ-029 When enable returns to 1, the block SHALL resume counting from the held pwm_cnt.

Reset
REQ-030 While reset=0 the block SHALL force pwm_out=0, busy=0, period_strobe=0, cmd_ready=0, pwm_cnt=0, all duty and target values to 0, all FSMs to IDLE, and the sync flops to 0.
REQ-031 Assertion of reset mid-fade or mid-period SHALL clear all state immediately, with no clk_in edge required.
REQ-032 cmd_ready SHALL rise on the 1st clk_in edge after reset deasserts.

Verification (WIDTH=4, MAX=15, CHANNELS=3)
REQ-033 Reset release, enable=1, cmd ch0 target=5 step=0, 15 toggles of tick_in -> pwm_out[0]=1 for pwm_cnt 0..4 and 0 for 5..14; period_strobe pulses once.
REQ-034 Cmd ch1 target=15 step=4 from duty 0 -> duty goes 4, 8, 12, 15 at successive wraps; busy[1] falls on the wrap that reaches 15; pwm_out[1] is then constantly 1.
REQ-035 Ch2 at 15, cmd target=2 step=6 -> duty goes 9, 3, 2 (clamped at target, no underflow); busy[2] falls after 3 wraps.
REQ-036 cmd_valid held high across a wrap -> cmd_ready=0 in the period_strobe cycle, and the command is accepted on the following cycle.
REQ-037 Mid-fade, set enable=0 for 40 ticks -> pwm_out=0, duty and pwm_cnt unchanged; on re-enable, counting and fading resume from the held values.
REQ-038 Assert reset mid-fade -> all outputs 0 immediately; cmd with cmd_channel=3 -> accepted, no effect on any channel.

Source files
------------

// File: rtl/led_pwm_fader.sv
// Multi-channel LED PWM generator with per-channel linear duty fades.
// PWM ticks come from an external divided clock; fades advance one step per PWM period.
module led_pwm_fader #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 3
) (
    input  logic                                                 clk_in,
    input  logic                                                 reset,
    input  logic                                                 tick_in,
    input  logic                                                 enable,
    input  logic                                                 cmd_valid,
    output logic                                                 cmd_ready,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]   cmd_channel,
    input  logic [WIDTH-1:0]                                     cmd_target,
    input  logic [WIDTH-1:0]                                     cmd_step,
    output logic [CHANNELS-1:0]                                  pwm_out,
    output logic [CHANNELS-1:0]                                  busy,
    output logic                                                 period_strobe
);

    localparam int               CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'((2 ** WIDTH) - 2);
    localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(CHANNELS);

    typedef enum logic [1:0] {
        IDLE,
        FADE_UP,
        FADE_DOWN
    } fade_state_t;

    function automatic logic [WIDTH-1:0] sat_step_up(input logic [WIDTH-1:0] duty,
                                                     input logic [WIDTH-1:0] step,
                                                     input logic [WIDTH-1:0] target);
        logic [WIDTH:0] sum;
        sum = {1'b0, duty} + {1'b0, step};
        if (sum >= {1'b0, target}) begin
            sat_step_up = target;
        end else begin
            sat_step_up = sum[WIDTH-1:0];
        end
    endfunction

    function automatic logic [WIDTH-1:0] sat_step_down(input logic [WIDTH-1:0] duty,
                                                       input logic [WIDTH-1:0] step,
                                                       input logic [WIDTH-1:0] target);
        logic signed [WIDTH+1:0] diff;
        diff = $signed({2'b00, duty}) - $signed({2'b00, step});
        if (diff <= $signed({2'b00, target})) begin
            sat_step_down = target;
        end else begin
            sat_step_down = diff[WIDTH-1:0];
        end
    endfunction

    // ---- stage p0..p2: tick synchroniser and edge detect ----
    logic sync_p0, sync_p1, sync_p2;
    logic vld_p2;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= tick_in;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    // Either polarity of change on the divided clock counts as one tick.
    assign vld_p2 = sync_p1 ^ sync_p2;

    // ---- period counter, wrap strobe and command handshake ----
    logic [WIDTH-1:0] pwm_cnt;
    logic             cnt_adv;
    logic             wrap_p2;

    assign cnt_adv = enable & vld_p2;
    assign wrap_p2 = cnt_adv & (pwm_cnt == CNT_LAST);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            pwm_cnt       <= '0;
            period_strobe <= 1'b0;
            cmd_ready     <= 1'b0;
        end else begin
            if (wrap_p2) begin
                pwm_cnt <= '0;
            end else if (cnt_adv) begin
                pwm_cnt <= pwm_cnt + WIDTH'(1);
            end
            period_strobe <= wrap_p2;
            // Ready drops in the strobe cycle so fade updates never meet a command.
            cmd_ready     <= ~wrap_p2;
        end
    end

    // ---- per-channel fade FSMs ----
    fade_state_t      state_q  [CHANNELS];
    fade_state_t      state_d  [CHANNELS];
    logic [WIDTH-1:0] duty_q   [CHANNELS];
    logic [WIDTH-1:0] duty_d   [CHANNELS];
    logic [WIDTH-1:0] target_q [CHANNELS];
    logic [WIDTH-1:0] target_d [CHANNELS];
    logic [WIDTH-1:0] step_q   [CHANNELS];
    logic [WIDTH-1:0] step_d   [CHANNELS];
    logic             cmd_accept;
    logic             fade_tick;

    // Out-of-range channel commands complete the handshake but touch nothing.
    assign cmd_accept = cmd_valid & cmd_ready & ({1'b0, cmd_channel} < CH_LIMIT);
    assign fade_tick  = period_strobe & enable;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i]  = state_q[i];
            duty_d[i]   = duty_q[i];
            target_d[i] = target_q[i];
            step_d[i]   = step_q[i];
            if (cmd_accept && (cmd_channel == CH_W'(i))) begin
                target_d[i] = cmd_target;
                step_d[i]   = cmd_step;
                if (cmd_step == '0) begin
                    duty_d[i]  = cmd_target;
                    state_d[i] = IDLE;
                end else if (cmd_target > duty_q[i]) begin
                    state_d[i] = FADE_UP;
                end else if (cmd_target < duty_q[i]) begin
                    state_d[i] = FADE_DOWN;
                end else begin
                    state_d[i] = IDLE;
                end
            end else if (fade_tick) begin
                case (state_q[i])
                    FADE_UP: begin
                        duty_d[i] = sat_step_up(duty_q[i], step_q[i], target_q[i]);
                        if (duty_d[i] == target_q[i]) begin
                            state_d[i] = IDLE;
                        end
                    end
                    FADE_DOWN: begin
                        duty_d[i] = sat_step_down(duty_q[i], step_q[i], target_q[i]);
                        if (duty_d[i] == target_q[i]) begin
                            state_d[i] = IDLE;
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= IDLE;
                duty_q[i]   <= '0;
                target_q[i] <= '0;
                step_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= state_d[i];
                duty_q[i]   <= duty_d[i];
                target_q[i] <= target_d[i];
                step_q[i]   <= step_d[i];
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            busy[i] = (state_q[i] != IDLE);
        end
    end

    // ---- output stage: registered PWM compare ----
    logic [CHANNELS-1:0] pwm_d;

    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = enable & (pwm_cnt < duty_q[i]);
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            pwm_out <= '0;
        end else begin
            pwm_out <= pwm_d;
        end
    end

endmodule
